sc_ifu: RTL
===========

SC_IFU -- requirements
Module: sc_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_LAT_MAX, default 15, maximum imem_gnt-to-imem_rvalid cycles counted by the watchdog.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pcsource  in  2  next-PC select from control unit: 00 pc+4, 01 branch, 10 jr, 11 jump/jal.
REQ-006 bpc  in  32  branch target.
REQ-007 jpc  in  32  jump target.
REQ-008 da  in  32  jr register operand.
REQ-009 imem_req  out  1  instruction-memory read request.
REQ-010 imem_addr  out  32  word-aligned fetch address.
REQ-011 imem_gnt  in  1  memory accepts request this cycle.
REQ-012 imem_rvalid  in  1  read data valid.
REQ-013 imem_rdata  in  32  read data.
REQ-014 inst  out  32  held instruction for decode.
REQ-015 pc  out  32  address of inst.
REQ-016 pc4  out  32  pc+4, for jal link.
REQ-017 inst_valid  out  1  inst/pc/pc4 valid.
REQ-018 inst_ready  in  1  downstream retires inst this cycle; pcsource/bpc/jpc/da valid in the same cycle.
REQ-019 misalign  out  1  one-cycle pulse: selected target had nonzero bits [1:0].
REQ-020 timeout  out  1  sticky: memory exceeded MEM_LAT_MAX.
REQ-021 retired  out  32  count of retired instructions.

Function
REQ-022 FSM states FETCH, WAIT, HOLD; exactly one instruction in flight, no speculative fetch.
REQ-023 FETCH: imem_req=1, imem_addr=pc; imem_gnt&~imem_rvalid -> WAIT; imem_gnt&imem_rvalid -> capture imem_rdata, go HOLD; no gnt -> stay FETCH, address held stable.
REQ-024 WAIT: imem_req=0; imem_rvalid -> capture imem_rdata into inst, go HOLD.
REQ-025 imem_rvalid outside WAIT, or in FETCH without imem_gnt, SHALL be ignored.
REQ-026 HOLD: inst_valid=1, inst stable; inst_ready -> load next PC, retired+1, go FETCH; otherwise stay HOLD.
REQ-027 inst_valid SHALL be 1 only in HOLD; inst_ready outside HOLD is ignored.
REQ-028 Next PC: pcsource 00 -> pc+4; 01 -> bpc; 10 -> da; 11 -> jpc; 32-bit add, wraps 32'hFFFF_FFFC -> 0.
REQ-029 Selected target bits [1:0] SHALL be forced 00; misalign pulses for one cycle (cycle after retire) when they were nonzero.
REQ-030 Latency: retire in HOLD -> imem_req in next cycle; zero-wait memory gives 2 cycles per instruction.
REQ-031 WAIT counter counts cycles since grant; reaching MEM_LAT_MAX without rvalid sets timeout and returns to FETCH re-requesting same pc; counter clears on leaving WAIT.
REQ-032 retired wraps 32'hFFFF_FFFF -> 0 silently.

Reset
REQ-033 reset SHALL dominate all inputs in its cycle, including mid-fetch and mid-HOLD.
REQ-034 Reset values: state FETCH, pc=RESET_PC, inst=0, inst_valid=0, misalign=0, timeout=0, retired=0, watchdog=0; imem_req=1 in the first post-reset cycle.
REQ-035 A response arriving after reset for a pre-reset request SHALL be dropped (state is FETCH, not WAIT).

Structure
REQ-036 Shared package sc_pkg: pcsource encodings (PC_SEQ, PC_BR, PC_JR, PC_J), FSM state enum, default RESET_PC.
REQ-037 One combinational sub-module sc_npc (pc, pcsource, bpc, jpc, da -> npc, misalign); the FSM, registers and counters stay in sc_ifu.

Verification
REQ-038 Reset, zero-wait memory (gnt&rvalid same cycle), inst_ready held 1, pcsource=00 -> imem_addr 0,4,8 every 2 cycles; retired=3 after third retire.
REQ-039 In HOLD at pc=0x10, pcsource=01, bpc=0x40 -> next imem_addr=0x40; pcsource=10, da=0x37 -> addr 0x34, misalign pulse 1 cycle.
REQ-040 gnt delayed 3 cycles, rvalid 2 cycles after gnt -> imem_addr stable throughout; inst captured once; inst_valid rises next cycle.
REQ-041 MEM_LAT_MAX=4, no rvalid after gnt -> timeout=1 after 4 WAIT cycles; re-request same pc; late rvalid in FETCH without gnt ignored.
REQ-042 reset asserted in WAIT with rvalid same cycle -> pc=RESET_PC, inst_valid=0, inst=0; next-cycle rvalid dropped.
REQ-043 pc=0xFFFF_FFFC, pcsource=00 -> next pc=0; retired preset path 0xFFFF_FFFF + retire -> 0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the single-cycle instruction fetch unit.
package sc_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JR  = 2'b10,
    PC_J   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/sc_ifu_if.sv
// Fetch-unit bundle: instruction-memory handshake plus decode-side hold/retire signals.
interface sc_ifu_if;
  import sc_pkg::*;

  logic [1:0]      pcsource;
  logic [XLEN-1:0] bpc;
  logic [XLEN-1:0] jpc;
  logic [XLEN-1:0] da;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic            inst_valid;
  logic            inst_ready;
  logic            misalign;
  logic            timeout;
  logic [XLEN-1:0] retired;

  modport master (
    output imem_req, imem_addr, inst, pc, pc4, inst_valid, misalign, timeout, retired,
    input  pcsource, bpc, jpc, da, imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, pc, pc4, inst_valid, misalign, timeout, retired,
    output pcsource, bpc, jpc, da, imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

endinterface

// File: rtl/sc_npc.sv
// Next-PC selection: picks the redirect target and forces word alignment.
module sc_npc
  import sc_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] jpc,
  input  logic [XLEN-1:0] da,
  output logic [XLEN-1:0] npc,
  output logic            misalign
);

  logic [XLEN-1:0] tgt;

  always_comb begin
    tgt = pc + 32'd4;
    unique case (pcsrc_e'(pcsource))
      PC_SEQ:  tgt = pc + 32'd4;
      PC_BR:   tgt = bpc;
      PC_JR:   tgt = da;
      PC_J:    tgt = jpc;
      default: tgt = pc + 32'd4;
    endcase
    misalign = |tgt[1:0];
    npc      = {tgt[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: one fetch in flight, holds the instruction until decode retires it.
module sc_ifu
  import sc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned     MEM_LAT_MAX = 15
) (
  input  logic      clock,
  input  logic      reset,
  sc_ifu_if.master  bus
);

  localparam int unsigned WDOG_W = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MEM_LAT_MAX - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   retired_q, retired_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              misalign_q, misalign_d;
  logic              imem_req_q, imem_req_d;
  logic              inst_valid_q, inst_valid_d;

  logic [XLEN-1:0]   npc;
  logic              npc_misalign;

  sc_npc u_npc (
    .pc       (pc_q),
    .pcsource (bus.pcsource),
    .bpc      (bus.bpc),
    .jpc      (bus.jpc),
    .da       (bus.da),
    .npc      (npc),
    .misalign (npc_misalign)
  );

  // Next-state and datapath updates; responses outside an open request are dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    inst_d     = inst_q;
    retired_d  = retired_q;
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
    misalign_d = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_gnt) begin
          wdog_d = '0;
          if (bus.imem_rvalid) begin
            inst_d  = bus.imem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          inst_d  = bus.imem_rdata;
          wdog_d  = '0;
          state_d = S_HOLD;
        end else if (wdog_q == WDOG_LAST) begin
          // Memory gave up on us: flag it and re-issue the same address.
          timeout_d = 1'b1;
          wdog_d    = '0;
          state_d   = S_FETCH;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          pc_d       = npc;
          pc4_d      = npc + 32'd4;
          retired_d  = retired_q + 32'd1;
          misalign_d = npc_misalign;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    imem_req_d   = (state_d == S_FETCH);
    inst_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pc4_q        <= RESET_PC + 32'd4;
      inst_q       <= '0;
      retired_q    <= '0;
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
      misalign_q   <= 1'b0;
      imem_req_q   <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      inst_q       <= inst_d;
      retired_q    <= retired_d;
      wdog_q       <= wdog_d;
      timeout_q    <= timeout_d;
      misalign_q   <= misalign_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.pc4        = pc4_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.timeout    = timeout_q;
  assign bus.retired    = retired_q;

endmodule
